// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit/receive pair: receiver state encoding,
// bus idle levels and a constant-evaluable ceil(log2) helper.
package spi_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CLR_IDLE  = 1'b1;

  // Smallest r with 2**r >= value.
  function automatic int clog_b2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous line, with an extra delay flop
// so that rising and falling edges of the synchronized level can be detected.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   dly_r;

  // Synchronizer chain and edge-detect delay flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
      dly_r  <= RESET_VAL;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      dly_r  <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level = sync_r[SYNC_STAGES-1];
  assign rise  = level & ~dly_r;
  assign fall  = ~level & dly_r;

endmodule

// File: rtl/spi_rx_if.sv
// Receive-side SPI deserializer (sclk idle low, MSB first, sample on sclk rise):
// delivers each well-formed frame as a parallel word and flags bad bit counts.
module spi_rx_if
  import spi_pkg::*;
#(
  parameter int DATA_SIZE   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 spi_clr_l,
  input  logic                 spi_cs_l,
  input  logic                 spi_sclk,
  input  logic                 spi_data,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 strobe_out,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int                CNT_W    = clog_b2(DATA_SIZE + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_SIZE);
  localparam logic [CNT_W-1:0]  CNT_OVR  = CNT_W'(DATA_SIZE + 1);

  logic cs_level_unused, cs_rise_s, cs_fall_s;
  logic sclk_level_unused, sclk_rise_s, sclk_fall_unused;
  logic data_s, data_rise_unused, data_fall_unused;
  logic clr_s, clr_rise_unused, clr_fall_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_cs_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_cs_l),
    .level(cs_level_unused), .rise(cs_rise_s), .fall(cs_fall_s));

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_sclk),
    .level(sclk_level_unused), .rise(sclk_rise_s), .fall(sclk_fall_unused));

  // Same depth as sclk so the sampled bit lines up with the detected rising edge.
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_data_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_data),
    .level(data_s), .rise(data_rise_unused), .fall(data_fall_unused));

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CLR_IDLE)) u_clr_sync (
    .clk(clk), .reset_n(reset_n), .din(spi_clr_l),
    .level(clr_s), .rise(clr_rise_unused), .fall(clr_fall_unused));

  rx_state_t            state_r, state_next_s;
  logic [CNT_W-1:0]     cnt_r, cnt_next_s, cnt_upd_s;
  logic [DATA_SIZE-1:0] shift_r, shift_next_s, shift_upd_s;
  logic [DATA_SIZE-1:0] word_next_s;
  logic                 strobe_next_s, err_next_s;

  // Next-state logic; a bit arriving with the cs rise is counted before the check.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    shift_next_s  = shift_r;
    word_next_s   = data_out;
    strobe_next_s = 1'b0;
    err_next_s    = 1'b0;
    if (sclk_rise_s) begin
      shift_upd_s = {shift_r[DATA_SIZE-2:0], data_s};
      cnt_upd_s   = (cnt_r == CNT_OVR) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      shift_upd_s = shift_r;
      cnt_upd_s   = cnt_r;
    end
    if (clr_s != CLR_IDLE) begin
      state_next_s = IDLE;
      cnt_next_s   = {CNT_W{1'b0}};
      word_next_s  = {DATA_SIZE{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_next_s = RECV;
            cnt_next_s   = {CNT_W{1'b0}};
            shift_next_s = {DATA_SIZE{1'b0}};
          end else begin
            state_next_s = IDLE;
          end
        end
        RECV: begin
          cnt_next_s   = cnt_upd_s;
          shift_next_s = shift_upd_s;
          if (cs_rise_s) begin
            state_next_s = IDLE;
            if (cnt_upd_s == CNT_FULL) begin
              word_next_s   = shift_upd_s;
              strobe_next_s = 1'b1;
            end else begin
              err_next_s = 1'b1;
            end
          end else begin
            state_next_s = RECV;
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      shift_r    <= {DATA_SIZE{1'b0}};
      data_out   <= {DATA_SIZE{1'b0}};
      strobe_out <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= cnt_next_s;
      shift_r    <= shift_next_s;
      data_out   <= word_next_s;
      strobe_out <= strobe_next_s;
      frame_err  <= err_next_s;
    end
  end

  assign busy = (state_r == RECV);

endmodule

// File: tb/tb_spi_rx_if.sv
// Directed bench for spi_rx_if: a frame-level model schedules the expected output
// events (fixed latency after each bus-line change) and a monitor compares every cycle.
module tb_spi_rx_if;

  localparam int DW   = 16;
  localparam int SS   = 2;
  localparam int LAT  = SS + 1;
  localparam int MAXC = 16384;

  localparam logic [4:0] EV_GOOD = 5'b00001;
  localparam logic [4:0] EV_ERR  = 5'b00010;
  localparam logic [4:0] EV_CLR  = 5'b00100;
  localparam logic [4:0] EV_BON  = 5'b01000;
  localparam logic [4:0] EV_BOFF = 5'b10000;

  logic clk = 1'b0;
  logic reset_n, spi_clr_l, spi_cs_l, spi_sclk, spi_data;
  logic [DW-1:0] data_out;
  logic strobe_out, frame_err, busy;

  spi_rx_if #(.DATA_SIZE(DW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .spi_clr_l(spi_clr_l), .spi_cs_l(spi_cs_l),
    .spi_sclk(spi_sclk), .spi_data(spi_data), .data_out(data_out),
    .strobe_out(strobe_out), .frame_err(frame_err), .busy(busy));

  always #5 clk = ~clk;

  int cyc = 0;
  logic [4:0]    ev_flags [MAXC];
  logic [DW-1:0] ev_word  [MAXC];
  logic [4:0]    fl_now;
  logic [DW-1:0] wd_now;
  logic exp_strobe, exp_err, exp_busy;
  logic [DW-1:0] exp_data;

  bit            live;
  int            mcnt;
  logic [DW-1:0] mword;

  int n_checks = 0, n_pass = 0;
  int n_strobe = 0, n_err = 0, last_strobe_cyc = 0, raise_cyc = 0;
  logic [DW-1:0] prev_sw = '0, last_sw = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Expected output effect appears LAT edges after the edge that first samples the change.
  task automatic sched(input logic [4:0] f, input logic [DW-1:0] w);
    int idx;
    idx = cyc + LAT;
    if (idx >= MAXC) begin
      n_checks++;
      $display("FAIL sched_range: event cycle %0d, limit %0d", idx, MAXC);
    end else begin
      ev_flags[idx] = ev_flags[idx] | f;
      if ((f & EV_GOOD) != 5'b0) ev_word[idx] = w;
    end
  endtask

  assign fl_now = (cyc + 1 < MAXC) ? ev_flags[cyc + 1] : 5'b0;
  assign wd_now = (cyc + 1 < MAXC) ? ev_word[cyc + 1] : '0;

  // Model output timeline.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) begin
      exp_strobe <= 1'b0;
      exp_err    <= 1'b0;
      exp_busy   <= 1'b0;
      exp_data   <= '0;
    end else begin
      exp_strobe <= fl_now[0];
      exp_err    <= fl_now[1];
      if (fl_now[2]) exp_data <= '0;
      else if (fl_now[0]) exp_data <= wd_now;
      if (fl_now[2] | fl_now[4]) exp_busy <= 1'b0;
      else if (fl_now[3]) exp_busy <= 1'b1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("strobe_out", {31'b0, strobe_out}, {31'b0, exp_strobe});
      chk("frame_err", {31'b0, frame_err}, {31'b0, exp_err});
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("data_out", {16'b0, data_out}, {16'b0, exp_data});
      chk("strobe_err_excl", {31'b0, strobe_out & frame_err}, 32'd0);
      if (strobe_out) begin
        n_strobe++;
        last_strobe_cyc = cyc;
        prev_sw = last_sw;
        last_sw = data_out;
      end
      if (frame_err) n_err++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall();
    @(negedge clk);
    spi_cs_l = 1'b0;
    if (spi_clr_l) begin
      live = 1'b1; mcnt = 0; mword = '0;
      sched(EV_BON, '0);
    end else begin
      live = 1'b0;
    end
  endtask

  // Data changes with sclk falling; caller is aligned to a negedge.
  task automatic send_bit(input logic b, input int half);
    spi_data = b;
    wait_neg(half);
    spi_sclk = 1'b1;
    if (live) begin
      if (mcnt < DW + 1) mcnt++;
      mword = {mword[DW-2:0], b};
    end
    wait_neg(half);
    spi_sclk = 1'b0;
  endtask

  task automatic cs_rise(input int half);
    wait_neg(half);
    spi_cs_l = 1'b1;
    raise_cyc = cyc;
    if (live) begin
      live = 1'b0;
      sched((mcnt == DW) ? (EV_GOOD | EV_BOFF) : (EV_ERR | EV_BOFF), mword);
    end
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits, input int half, input int gap);
    cs_fall();
    for (int i = nbits - 1; i >= 0; i--) send_bit(val[i], half);
    cs_rise(half);
    wait_neg(gap);
  endtask

  task automatic clr_pulse(input int n);
    @(negedge clk);
    spi_clr_l = 1'b0;
    live = 1'b0;
    sched(EV_CLR, '0);
    wait_neg(n);
    spi_clr_l = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  int s0, e0;
  logic [DW-1:0] w;

  initial begin
    reset_n = 1'b0; spi_clr_l = 1'b1; spi_cs_l = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0;
    live = 1'b0; mcnt = 0; mword = '0;
    for (int i = 0; i < MAXC; i++) begin ev_flags[i] = 5'b0; ev_word[i] = '0; end
    wait_neg(3);
    chk("rst_data", {16'b0, data_out}, 32'd0);
    chk("rst_strobe", {31'b0, strobe_out}, 32'd0);
    chk("rst_err", {31'b0, frame_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    wait_neg(4);

    // 1: basic frame, latency
    s0 = n_strobe; e0 = n_err;
    send_frame(32'hA5C3, 16, 4, 8); #1;
    chk("t1_data", {16'b0, data_out}, 32'h0000A5C3);
    chk("t1_strobes", n_strobe - s0, 32'd1);
    chk("t1_errs", n_err - e0, 32'd0);
    chk("t1_latency", last_strobe_cyc - raise_cyc, 32'd3);

    // 2: back-to-back frames
    s0 = n_strobe;
    send_frame(32'h0001, 16, 4, 4);
    send_frame(32'hFFFF, 16, 4, 8); #1;
    chk("t2_strobes", n_strobe - s0, 32'd2);
    chk("t2_word0", {16'b0, prev_sw}, 32'h00000001);
    chk("t2_word1", {16'b0, last_sw}, 32'h0000FFFF);

    // 3: short and long frames
    send_frame(32'hA5C3, 16, 4, 8);
    s0 = n_strobe; e0 = n_err;
    send_frame(32'h7FFF, 15, 4, 8); #1;
    chk("t3_short_err", n_err - e0, 32'd1);
    chk("t3_short_data", {16'b0, data_out}, 32'h0000A5C3);
    send_frame(32'h1B3C5, 17, 4, 8); #1;
    chk("t3_long_err", n_err - e0, 32'd2);
    chk("t3_long_data", {16'b0, data_out}, 32'h0000A5C3);
    chk("t3_no_strobe", n_strobe - s0, 32'd0);

    // 4: clear mid-frame; cs still low at release
    s0 = n_strobe; e0 = n_err;
    cs_fall();
    for (int i = 7; i >= 0; i--) send_bit(i[0], 4);
    clr_pulse(4);
    wait_neg(6); #1;
    chk("t4_data", {16'b0, data_out}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 4);
    cs_rise(4);
    wait_neg(8); #1;
    chk("t4_no_pulse", (n_strobe - s0) + (n_err - e0), 32'd0);
    send_frame(32'h1234, 16, 4, 8); #1;
    chk("t4_after", {16'b0, data_out}, 32'h00001234);

    // 5: reset mid-frame
    cs_fall();
    for (int i = 9; i >= 0; i--) send_bit(1'b1, 4);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_data", {16'b0, data_out}, 32'd0);
    chk("t5_strobe", {31'b0, strobe_out}, 32'd0);
    chk("t5_err", {31'b0, frame_err}, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    live = 1'b0;
    for (int i = cyc; i < cyc + LAT + 4 && i < MAXC; i++) ev_flags[i] = 5'b0;
    spi_cs_l = 1'b1; spi_sclk = 1'b0;
    wait_neg(3);
    reset_n = 1'b1;
    wait_neg(4);
    send_frame(32'h8000, 16, 4, 8); #1;
    chk("t5_after", {16'b0, data_out}, 32'h00008000);

    // 6: loopback at the 2:1 clock ratio limit
    clr_pulse(4);
    wait_neg(6);
    s0 = n_strobe; e0 = n_err; w = '0;
    for (int k = 0; k < 100; k++) begin
      w = DW'($urandom);
      send_frame({16'b0, w}, 16, 2, 2);
    end
    wait_neg(8); #1;
    chk("t6_strobes", n_strobe - s0, 32'd100);
    chk("t6_errs", n_err - e0, 32'd0);
    chk("t6_last", {16'b0, data_out}, {16'b0, w});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_rx_if.md
Name: spi_rx_if

Overview:
Receive-side SPI interface: deserializes frames produced by the team's SPI transmitter (sclk idle low, MSB first, data changing on sclk falling edge, active-low chip select and clear). All four SPI lines are asynchronous to clk and are synchronized internally. Each complete frame is presented as a parallel word with a one-cycle valid strobe. Malformed frames are flagged. Used on the peripheral/loopback side of SPI-controlled blocks such as DAC/attenuator emulators and the bench loopback.

Parameters:
DATA_SIZE, 16, bits per frame (>= 2)
SYNC_STAGES, 2, synchronizer flops per SPI input (>= 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
spi_clr_l  in  1  active-low SPI bus clear (async)
spi_cs_l  in  1  active-low chip select (async)
spi_sclk  in  1  SPI clock (async)
spi_data  in  1  SPI serial data (async)
data_out  out  DATA_SIZE  last good received word
strobe_out  out  1  one-cycle pulse: data_out updated
frame_err  out  1  one-cycle pulse: frame ended with wrong bit count
busy  out  1  high while a frame is in progress

Behaviour:
- Reset is decided: reset_n asynchronous, active-low; clock clk. Reset values: data_out=0, strobe_out=0, frame_err=0, busy=0, FSM=IDLE, bit counter=0, shifter=0, all synchronizer flops: cs=1, clr=1, sclk=0, data=0.
- Sync: each input passes through SYNC_STAGES flops (cs_s, sclk_s, data_s, clr_s), plus one delay flop on cs_s and sclk_s for edge detection. data_s shares its pipeline depth with sclk_s.
- Clock-ratio constraint: each sclk high and low phase must last >= 2 clk periods. This holds when the receiver clk is at least twice the transmitter clk.
- Bit counter width is clog2(DATA_SIZE+1). It saturates at DATA_SIZE+1.
- FSM states: IDLE, RECV.
  - IDLE -> RECV on cs_s falling edge. Counter cleared, shifter cleared.
  - RECV, sclk_s rising edge: shifter <= {shifter[DATA_SIZE-2:0], data_s}, counter++ (saturating).
  - RECV, cs_s rising edge -> IDLE.
    - If counter == DATA_SIZE: data_out <= shifter, strobe_out pulses.
    - Otherwise: frame_err pulses and data_out holds its value.
- Latency: strobe_out/frame_err assert after clk edge SYNC_STAGES+1, counted from the first edge that samples spi_cs_l high. data_out is valid in the same cycle as strobe_out and holds until the next good frame or a clear.
- A sclk rising edge in the same cycle as the cs rising edge is shifted in before the count check.
- A sclk rising edge in the same cycle as the cs falling edge is ignored.
- sclk edges while in IDLE are ignored.
- Overrun: more than DATA_SIZE rising edges sets the counter to DATA_SIZE+1. This yields frame_err at cs deassertion; the shifter keeps only the last DATA_SIZE bits, but they are discarded.
- clr_s low (level): data_out <= 0, FSM -> IDLE, counter=0, no strobe or err for the aborted frame. clr has priority over all other events. If cs is still low when clr releases, the receiver waits for the next cs falling edge.
- busy = (state == RECV).
- reset_n asserted mid-frame: immediate return to reset values, no pulses emitted.
- strobe_out and frame_err are never high in the same cycle.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (IDLE/RECV)
  - clog_b2 function
  - idle-level constants: CS_IDLE=1, SCLK_IDLE=0, CLR_IDLE=1 (shared with the transmitter)
- Sub-module sync_edge_det:
  - Parameters: SYNC_STAGES, RESET_VAL.
  - Outputs: synchronized level, rise pulse, fall pulse.
  - Instantiated for cs and sclk. data and clr use level-only instances, rise/fall unused.

Test Plan:
1. Frame 0xA5C3, 16 sclk pulses, sclk period 8 clk -> data_out=0xA5C3, strobe_out high exactly 1 cycle at edge SYNC_STAGES+1 after cs rise, frame_err=0.
2. Back-to-back frames 0x0001 then 0xFFFF, cs high for 4 clk between them -> two strobes; data_out=0x0001 then 0xFFFF.
3. Short frame, 15 bits -> frame_err pulse, no strobe, data_out keeps prior value 0xA5C3. Long frame, 17 bits -> same response.
4. spi_clr_l low for 4 clk mid-frame after 8 bits -> data_out=0, busy=0, no strobe/err. The next full frame 0x1234 is received correctly.
5. reset_n asserted after 10 bits -> all outputs 0 asynchronously. After release, frame 0x8000 -> data_out=0x8000.
6. Loopback with the transmitter, receiver clk = 2x transmitter clk, 100 random words, clr pulse at start -> every word matches, zero frame_err.
